// File: rtl/inter_arb_param.sv
// -----------------------------------------------------------------------------
// inter_arb_param
// Parametrised N-master -> M-slave write interconnect. Each master owns a
// one-entry holding buffer; a single registered output port is shared by all
// slaves and granted by fixed-priority or round-robin arbitration. Packets
// whose slave select is out of range are dropped and flagged.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   in_valid[i]      master i offers a packet
//   in_ready[i]      master i buffer is empty (0 while rst)
//   data_in          master i packet {sel, addr, value} at [i*PKT_W +: PKT_W]
//   ready_slave[j]   slave j can accept
//   valid_slave[j]   one-hot: packet on addr_out/value_out is for slave j
//   addr_out         address of the granted packet
//   value_out        value of the granted packet
//   grant_id         index of the master being served
//   handshake_slave  one-cycle pulse the cycle after slave j completes a transfer
//   drop_err         one-cycle pulse after a packet with sel >= NUM_SLV is dropped
// -----------------------------------------------------------------------------
module inter_arb_param #(
    parameter int NUM_MST  = 3,
    parameter int NUM_SLV  = 2,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 3,
    parameter int ARB_MODE = 0,
    localparam int MST_W   = $clog2(NUM_MST),
    localparam int SEL_W   = $clog2(NUM_SLV),
    localparam int PKT_W   = SEL_W + ADDR_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_MST-1:0]       in_valid,
    output logic [NUM_MST-1:0]       in_ready,
    input  logic [NUM_MST*PKT_W-1:0] data_in,
    input  logic [NUM_SLV-1:0]       ready_slave,
    output logic [NUM_SLV-1:0]       valid_slave,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [DATA_W-1:0]        value_out,
    output logic [MST_W-1:0]         grant_id,
    output logic [NUM_SLV-1:0]       handshake_slave,
    output logic                     drop_err
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t             state_q, state_d;
    logic [NUM_MST-1:0] pend_q, pend_d;
    logic [PKT_W-1:0]   buf_q [NUM_MST];
    logic [PKT_W-1:0]   buf_d [NUM_MST];
    logic [NUM_SLV-1:0] valid_slave_q, valid_slave_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  value_q, value_d;
    logic [MST_W-1:0]   grant_q, grant_d;
    logic [NUM_SLV-1:0] hs_q, hs_d;
    logic               drop_q, drop_d;
    logic [MST_W-1:0]   rr_q, rr_d;

    logic               transfer;
    logic [NUM_MST-1:0] cand;
    logic               win_found;
    logic [MST_W-1:0]   win_idx;
    logic [PKT_W-1:0]   win_pkt;
    logic [SEL_W-1:0]   win_sel;
    logic               win_drop;
    logic               do_grant;

    assign transfer = (state_q == ST_SEND) && (|(valid_slave_q & ready_slave));

    // While a transfer completes, the master just served is still pending
    // this cycle; mask it so the same-edge re-grant goes to someone else.
    always_comb begin
        cand = pend_q;
        if (state_q == ST_SEND) begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (MST_W'(i) == grant_q) cand[i] = 1'b0;
            end
        end
    end

    // Loops run from the far end so the last hit is the winner: lowest index
    // for fixed priority, first index after rr_q (wrapping) for round-robin.
    always_comb begin
        logic [MST_W-1:0] idx;
        int               sum;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        sum       = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_MST - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    win_found = 1'b1;
                    win_idx   = MST_W'(i);
                end
            end
        end else begin
            for (int k = NUM_MST; k >= 1; k--) begin
                sum = int'(rr_q) + k;
                if (sum >= NUM_MST) sum = sum - NUM_MST;
                idx = MST_W'(sum);
                if (cand[idx]) begin
                    win_found = 1'b1;
                    win_idx   = idx;
                end
            end
        end
    end

    assign win_pkt  = buf_q[win_idx];
    assign win_sel  = win_pkt[PKT_W-1 -: SEL_W];
    assign win_drop = (int'(win_sel) >= NUM_SLV);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        buf_d         = buf_q;
        valid_slave_d = valid_slave_q;
        addr_d        = addr_q;
        value_d       = value_q;
        grant_d       = grant_q;
        hs_d          = '0;
        drop_d        = 1'b0;
        rr_d          = rr_q;
        do_grant      = 1'b0;

        // Capture into empty buffers only; a pending buffer is never overwritten.
        for (int i = 0; i < NUM_MST; i++) begin
            if (in_valid[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
                buf_d[i]  = data_in[i*PKT_W +: PKT_W];
            end
        end

        case (state_q)
            ST_IDLE: do_grant = win_found;
            ST_SEND: begin
                if (transfer) begin
                    pend_d[grant_q] = 1'b0;
                    hs_d            = valid_slave_q & ready_slave;
                    valid_slave_d   = '0;
                    addr_d          = '0;
                    value_d         = '0;
                    grant_d         = '0;
                    state_d         = ST_IDLE;
                    do_grant        = win_found;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A dropped winner is retired at its grant edge and never reaches the
        // output port; the outputs stay cleared and arbitration resumes.
        if (do_grant) begin
            rr_d = win_idx;
            if (win_drop) begin
                pend_d[win_idx] = 1'b0;
                drop_d          = 1'b1;
                state_d         = ST_IDLE;
            end else begin
                state_d = ST_SEND;
                for (int j = 0; j < NUM_SLV; j++) begin
                    valid_slave_d[j] = (int'(win_sel) == j);
                end
                addr_d  = win_pkt[DATA_W +: ADDR_W];
                value_d = win_pkt[DATA_W-1:0];
                grant_d = win_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pend_q        <= '0;
            valid_slave_q <= '0;
            addr_q        <= '0;
            value_q       <= '0;
            grant_q       <= '0;
            hs_q          <= '0;
            drop_q        <= 1'b0;
            rr_q          <= MST_W'(NUM_MST - 1);
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            valid_slave_q <= valid_slave_d;
            addr_q        <= addr_d;
            value_q       <= value_d;
            grant_q       <= grant_d;
            hs_q          <= hs_d;
            drop_q        <= drop_d;
            rr_q          <= rr_d;
        end
    end

    // NOTE: the packet buffers carry no reset; their contents are only ever
    // read while the matching pend bit is set, and pend is reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign in_ready        = rst ? '0 : ~pend_q;
    assign valid_slave     = valid_slave_q;
    assign addr_out        = addr_q;
    assign value_out       = value_q;
    assign grant_id        = grant_q;
    assign handshake_slave = hs_q;
    assign drop_err        = drop_q;

endmodule

// File: tb/tb_inter_arb_param.sv
// -----------------------------------------------------------------------------
// tb_inter_arb_param
// Two instances: u_fp (3 masters, 2 slaves, fixed priority) and u_rr
// (3 masters, 3 slaves, round-robin). Expected transfers are queued when a
// packet is offered and popped by a monitor whenever a slave handshake
// completes; directed checks cover reset, latency, back-pressure, drop and
// reset during a transfer.
// -----------------------------------------------------------------------------
module tb_inter_arb_param;

    logic clk;
    logic rst;

    // Fixed-priority instance: PKT_W = 1 + 3 + 3 = 7
    logic [2:0]  in_valid_a;
    logic [2:0]  in_ready_a;
    logic [20:0] data_a;
    logic [1:0]  ready_a;
    logic [1:0]  valid_a;
    logic [2:0]  addr_a;
    logic [2:0]  value_a;
    logic [1:0]  gid_a;
    logic [1:0]  hs_a;
    logic        drop_a;

    // Round-robin instance: PKT_W = 2 + 3 + 3 = 8
    logic [2:0]  in_valid_b;
    logic [2:0]  in_ready_b;
    logic [23:0] data_b;
    logic [2:0]  ready_b;
    logic [2:0]  valid_b;
    logic [2:0]  addr_b;
    logic [2:0]  value_b;
    logic [1:0]  gid_b;
    logic [2:0]  hs_b;
    logic        drop_b;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q_fp[$];
    logic [31:0] q_rr[$];

    inter_arb_param #(
        .NUM_MST(3), .NUM_SLV(2), .ADDR_W(3), .DATA_W(3), .ARB_MODE(0)
    ) u_fp (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .data_in(data_a),
        .ready_slave(ready_a), .valid_slave(valid_a),
        .addr_out(addr_a), .value_out(value_a), .grant_id(gid_a),
        .handshake_slave(hs_a), .drop_err(drop_a)
    );

    inter_arb_param #(
        .NUM_MST(3), .NUM_SLV(3), .ADDR_W(3), .DATA_W(3), .ARB_MODE(1)
    ) u_rr (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .data_in(data_b),
        .ready_slave(ready_b), .valid_slave(valid_b),
        .addr_out(addr_b), .value_out(value_b), .grant_id(gid_b),
        .handshake_slave(hs_b), .drop_err(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] g, input logic [7:0] vs,
                                       input logic [7:0] a, input logic [7:0] v);
        return {g, vs, a, v};
    endfunction

    function automatic logic [6:0] pkt_a(input logic sel, input logic [2:0] a, input logic [2:0] v);
        return {sel, a, v};
    endfunction

    function automatic logic [7:0] pkt_b(input logic [1:0] sel, input logic [2:0] a, input logic [2:0] v);
        return {sel, a, v};
    endfunction

    function automatic logic [31:0] obs_a();
        return pk(8'(gid_a), 8'(valid_a), 8'(addr_a), 8'(value_a));
    endfunction

    function automatic logic [31:0] obs_b();
        return pk(8'(gid_b), 8'(valid_b), 8'(addr_b), 8'(value_b));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a transfer is valid & ready seen before the edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (|(valid_a & ready_a)) begin
                if (q_fp.size() == 0) check("fp_sb_unexpected", obs_a(), 32'd0);
                else check("fp_xfer", obs_a(), q_fp.pop_front());
            end
            if (|(valid_b & ready_b)) begin
                if (q_rr.size() == 0) check("rr_sb_unexpected", obs_b(), 32'd0);
                else check("rr_xfer", obs_b(), q_rr.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        in_valid_a = '0; data_a = '0; ready_a = '0;
        in_valid_b = '0; data_b = '0; ready_b = '0;

        // ---- reset held two cycles
        tick();
        check("rst_in_ready_a", 32'(in_ready_a), 32'd0);
        check("rst_in_ready_b", 32'(in_ready_b), 32'd0);
        check("rst_outs_a", {obs_a()[31:8], 8'(value_a)} | 32'(hs_a) | 32'(drop_a), 32'd0);
        check("rst_outs_b", obs_b() | 32'(hs_b) | 32'(drop_b), 32'd0);
        tick();
        check("rst2_in_ready_a", 32'(in_ready_a), 32'd0);
        rst = 1'b0;
        tick();
        check("rel_in_ready_a", 32'(in_ready_a), 32'h7);
        check("rel_in_ready_b", 32'(in_ready_b), 32'h7);

        // ---- single packet from master 1 to slave 1
        in_valid_a       = 3'b010;
        data_a[7 +: 7]   = pkt_a(1'b1, 3'd5, 3'd3);
        ready_a          = 2'b10;
        q_fp.push_back(pk(8'd1, 8'b10, 8'd5, 8'd3));
        tick();                                  // capture edge
        in_valid_a = '0;
        check("single_in_ready_busy", 32'(in_ready_a), 32'h5);
        check("single_not_yet", 32'(valid_a), 32'd0);
        tick();                                  // grant edge
        check("single_out", obs_a(), pk(8'd1, 8'b10, 8'd5, 8'd3));
        tick();                                  // transfer edge
        check("single_hs", 32'(hs_a), 32'h2);
        check("single_idle", 32'(valid_a), 32'd0);
        check("single_in_ready_back", 32'(in_ready_a), 32'h7);
        tick();
        check("single_hs_pulse_end", 32'(hs_a), 32'd0);

        // ---- fixed priority: all three at once, served back-to-back 0,1,2
        in_valid_a      = 3'b111;
        data_a[0 +: 7]  = pkt_a(1'b0, 3'd1, 3'd1);
        data_a[7 +: 7]  = pkt_a(1'b1, 3'd2, 3'd2);
        data_a[14 +: 7] = pkt_a(1'b0, 3'd3, 3'd4);
        ready_a         = 2'b11;
        q_fp.push_back(pk(8'd0, 8'b01, 8'd1, 8'd1));
        q_fp.push_back(pk(8'd1, 8'b10, 8'd2, 8'd2));
        q_fp.push_back(pk(8'd2, 8'b01, 8'd3, 8'd4));
        tick();
        in_valid_a = '0;
        tick();
        check("fp_grant0", obs_a(), pk(8'd0, 8'b01, 8'd1, 8'd1));
        tick();
        check("fp_grant1", obs_a(), pk(8'd1, 8'b10, 8'd2, 8'd2));
        check("fp_hs0", 32'(hs_a), 32'h1);
        tick();
        check("fp_grant2", obs_a(), pk(8'd2, 8'b01, 8'd3, 8'd4));
        check("fp_hs1", 32'(hs_a), 32'h2);
        tick();
        check("fp_done", obs_a(), 32'd0);
        check("fp_hs2", 32'(hs_a), 32'h1);

        // ---- back-pressure: ten stalled cycles, second offer ignored
        ready_a        = 2'b00;
        in_valid_a     = 3'b001;
        data_a[0 +: 7] = pkt_a(1'b1, 3'd6, 3'd7);
        q_fp.push_back(pk(8'd0, 8'b10, 8'd6, 8'd7));
        tick();
        data_a[0 +: 7] = pkt_a(1'b0, 3'd2, 3'd2);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("stall_hold", obs_a(), pk(8'd0, 8'b10, 8'd6, 8'd7));
        end
        in_valid_a = '0;
        ready_a    = 2'b01;                      // other slave's ready is ignored
        tick();
        check("stall_wrong_slave", obs_a(), pk(8'd0, 8'b10, 8'd6, 8'd7));
        ready_a = 2'b10;
        tick();
        check("stall_hs", 32'(hs_a), 32'h2);
        check("stall_idle", 32'(valid_a), 32'd0);
        check("stall_in_ready", 32'(in_ready_a), 32'h7);
        ready_a = 2'b00;

        // ---- round-robin: masters 0 and 2 keep re-issuing, grants alternate
        in_valid_b      = 3'b101;
        data_b[0 +: 8]  = pkt_b(2'd0, 3'd1, 3'd1);
        data_b[16 +: 8] = pkt_b(2'd2, 3'd3, 3'd3);
        ready_b         = 3'b111;
        q_rr.push_back(pk(8'd0, 8'b001, 8'd1, 8'd1));
        q_rr.push_back(pk(8'd2, 8'b100, 8'd3, 8'd3));
        q_rr.push_back(pk(8'd0, 8'b001, 8'd1, 8'd1));
        q_rr.push_back(pk(8'd2, 8'b100, 8'd3, 8'd3));
        for (int c = 0; c < 30 && q_rr.size() > 0; c++) begin
            tick();
            if (q_rr.size() <= 1) in_valid_b = '0;
        end
        check("alt_all_served", 32'(q_rr.size()), 32'd0);
        in_valid_b = '0;
        tick();
        check("alt_idle", 32'(valid_b), 32'd0);
        check("alt_in_ready", 32'(in_ready_b), 32'h7);

        // ---- round-robin with three pending: after master 1, master 2 wins over 0
        ready_b         = 3'b000;
        in_valid_b      = 3'b111;
        data_b[0 +: 8]  = pkt_b(2'd0, 3'd4, 3'd1);
        data_b[8 +: 8]  = pkt_b(2'd1, 3'd5, 3'd2);
        data_b[16 +: 8] = pkt_b(2'd2, 3'd6, 3'd3);
        q_rr.push_back(pk(8'd0, 8'b001, 8'd4, 8'd1));
        q_rr.push_back(pk(8'd1, 8'b010, 8'd5, 8'd2));
        q_rr.push_back(pk(8'd2, 8'b100, 8'd6, 8'd3));
        q_rr.push_back(pk(8'd0, 8'b001, 8'd7, 8'd4));
        tick();
        in_valid_b = '0;
        tick();
        check("rr3_first", 32'(gid_b), 32'd0);
        ready_b = 3'b001;
        tick();
        check("rr3_second", 32'(gid_b), 32'd1);
        ready_b        = 3'b000;
        in_valid_b     = 3'b001;
        data_b[0 +: 8] = pkt_b(2'd0, 3'd7, 3'd4);
        tick();
        in_valid_b = '0;
        check("rr3_all_pending", 32'(in_ready_b), 32'd0);
        ready_b = 3'b010;
        tick();
        check("rr3_skip_master0", obs_b(), pk(8'd2, 8'b100, 8'd6, 8'd3));
        ready_b = 3'b100;
        tick();
        check("rr3_fourth", obs_b(), pk(8'd0, 8'b001, 8'd7, 8'd4));
        ready_b = 3'b001;
        tick();
        check("rr3_idle", 32'(valid_b), 32'd0);
        ready_b = 3'b000;

        // ---- out-of-range select is dropped
        in_valid_b     = 3'b010;
        data_b[8 +: 8] = pkt_b(2'd3, 3'd2, 3'd5);
        tick();
        in_valid_b = '0;
        tick();
        check("drop_pulse", 32'(drop_b), 32'd1);
        check("drop_no_valid", 32'(valid_b), 32'd0);
        check("drop_pend_cleared", 32'(in_ready_b), 32'h7);
        tick();
        check("drop_pulse_once", 32'(drop_b), 32'd0);

        // ---- reset during SEND discards the in-flight packet
        in_valid_b     = 3'b001;
        data_b[0 +: 8] = pkt_b(2'd2, 3'd3, 3'd3);
        tick();
        in_valid_b = '0;
        tick();
        check("rstsend_out", obs_b(), pk(8'd0, 8'b100, 8'd3, 8'd3));
        rst = 1'b1;
        tick();
        check("rstsend_cleared", obs_b() | 32'(hs_b) | 32'(drop_b), 32'd0);
        check("rstsend_in_ready", 32'(in_ready_b), 32'd0);
        rst     = 1'b0;
        ready_b = 3'b100;
        tick();
        check("rstsend_no_valid", 32'(valid_b), 32'd0);
        check("rstsend_no_hs", 32'(hs_b), 32'd0);
        check("rstsend_in_ready_back", 32'(in_ready_b), 32'h7);
        ready_b = 3'b000;
        tick();

        check("fp_sb_drained", 32'(q_fp.size()), 32'd0);
        check("rr_sb_drained", 32'(q_rr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
